// File: rtl/mel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mel_pkg
// Brief    : Types and constants shared between the mel filterbank and the
//            band framer (band count, sample width, framer FSM states).
// Revision : 1.0 - initial release
// ============================================================================
package mel_pkg;

    localparam int NUM_BANDS = 15;
    localparam int IN_W      = 16;

    typedef logic signed [IN_W-1:0] band_sample_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } framer_state_t;

endpackage
`default_nettype wire

// File: rtl/band_accum.sv
`default_nettype none
// ============================================================================
// Module   : band_accum
// Brief    : One band's magnitude accumulator. Takes |sample| on each tick the
//            band is valid, clears at frame end, and presents the scaled and
//            saturated frame total (including the current sample).
// Revision : 1.0 - initial release
// ============================================================================
module band_accum #(
    parameter int IN_W      = 16,
    parameter int ACC_W     = 25,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic signed [IN_W-1:0] sample,
    input  logic                   sample_valid,
    input  logic                   tick,
    input  logic                   frame_end,
    output logic [OUT_W-1:0]       scaled
);

    logic signed [IN_W:0] w_ext;
    logic [IN_W:0]        w_mag;
    logic [ACC_W-1:0]     w_add;
    logic [ACC_W-1:0]     w_sum;
    logic [ACC_W-1:0]     w_shifted;
    logic [ACC_W-1:0]     r_acc;

    // One extra bit so the most negative sample has a representable magnitude.
    assign w_ext     = {sample[IN_W-1], sample};
    assign w_mag     = w_ext[IN_W] ? $unsigned(-w_ext) : $unsigned(w_ext);
    assign w_add     = sample_valid ? {{(ACC_W-IN_W-1){1'b0}}, w_mag} : '0;
    assign w_sum     = r_acc + w_add;
    assign w_shifted = w_sum >> OUT_SHIFT;

    generate
        if (ACC_W > OUT_W) begin : g_sat
            assign scaled = (|w_shifted[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}}
                                                        : w_shifted[OUT_W-1:0];
        end else begin : g_nosat
            assign scaled = OUT_W'(w_shifted);
        end
    endgenerate

    // Accumulate on every tick; a frame-end tick restarts the total from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (tick) begin
            r_acc <= frame_end ? '0 : w_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mel_band_framer.sv
`default_nettype none
// ============================================================================
// Module   : mel_band_framer
// Brief    : Accumulates per-band magnitude over FRAME_LEN ticks, snapshots
//            the scaled totals into a one-frame buffer and streams them as
//            NUM_BANDS feature words on valid/ready. Frames completing while
//            the buffer is still busy are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module mel_band_framer
    import mel_pkg::*;
#(
    parameter int FRAME_LEN = 256,
    parameter int OUT_W     = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  band_sample_t         band_in [NUM_BANDS],
    input  logic [NUM_BANDS-1:0] band_valid,
    output logic [OUT_W-1:0]     feat_data,
    output logic [3:0]           feat_band,
    output logic                 feat_valid,
    input  logic                 feat_ready,
    output logic                 feat_last,
    output logic                 overrun,
    output logic [7:0]           drop_count
);

    localparam int               c_cnt_w     = $clog2(FRAME_LEN);
    localparam int               c_acc_w     = IN_W + 1 + c_cnt_w;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FRAME_LEN - 1);
    localparam logic [3:0]       c_band_last = 4'(NUM_BANDS - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    logic               w_frame_end;
    logic [OUT_W-1:0]   w_scaled [NUM_BANDS];
    logic [OUT_W-1:0]   r_buf    [NUM_BANDS];

    framer_state_t      r_state;
    framer_state_t      w_state_next;
    logic [3:0]         r_band;
    logic [3:0]         w_band_next;
    logic               w_handshake;
    logic               w_is_last;
    logic               w_buf_free;
    logic               w_load;
    logic               w_drop;
    logic               r_overrun;
    logic [7:0]         r_drop_count;

    assign w_tick      = |band_valid;
    assign w_frame_end = w_tick && (r_cnt == c_cnt_last);

    generate
        for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_band
            band_accum #(
                .IN_W      (IN_W),
                .ACC_W     (c_acc_w),
                .OUT_W     (OUT_W),
                .OUT_SHIFT (OUT_SHIFT)
            ) u_accum (
                .clk          (clk),
                .rst          (rst),
                .sample       (band_in[gi]),
                .sample_valid (band_valid[gi]),
                .tick         (w_tick),
                .frame_end    (w_frame_end),
                .scaled       (w_scaled[gi])
            );
        end
    endgenerate

    // Tick counter; the tick seen at FRAME_LEN-1 closes the frame and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= w_frame_end ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_handshake = (r_state == SEND) && feat_ready;
    assign w_is_last   = (r_band == c_band_last);
    // The buffer can take a new frame in the same cycle the last beat leaves.
    assign w_buf_free  = (r_state == EMPTY) || (w_handshake && w_is_last);

    // Next-state logic: stream advance, frame load, or frame drop.
    always_comb begin
        w_state_next = r_state;
        w_band_next  = r_band;
        w_load       = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            EMPTY: begin
                w_state_next = EMPTY;
            end
            SEND: begin
                if (w_handshake) begin
                    if (w_is_last) begin
                        w_state_next = EMPTY;
                    end else begin
                        w_band_next = r_band + 4'd1;
                    end
                end
            end
            default: begin
                w_state_next = EMPTY;
            end
        endcase
        if (w_frame_end) begin
            if (w_buf_free) begin
                w_load       = 1'b1;
                w_state_next = SEND;
                w_band_next  = '0;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    // State and beat-index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_band  <= '0;
        end else begin
            r_state <= w_state_next;
            r_band  <= w_band_next;
        end
    end

    // Output buffer snapshot of the completed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_load) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                r_buf[i] <= w_scaled[i];
            end
        end
    end

    // Overrun pulse and saturating dropped-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun    <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_overrun <= w_drop;
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign feat_valid = (r_state == SEND);
    assign feat_band  = r_band;
    assign feat_data  = r_buf[r_band];
    assign feat_last  = feat_valid && w_is_last;
    assign overrun    = r_overrun;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_mel_band_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mel_band_framer
// Brief    : Directed scoreboard bench for mel_band_framer. A second instance
//            with OUT_SHIFT=0 shares the stimulus to exercise saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mel_band_framer;
    import mel_pkg::*;

    localparam int FL = 256;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  band;
        logic        last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    band_sample_t         tb_in [NUM_BANDS];
    logic [NUM_BANDS-1:0] tb_valid = '0;
    logic                 tb_ready = 1'b1;

    logic [15:0] feat_data,  sat_data;
    logic [3:0]  feat_band,  sat_band;
    logic        feat_valid, sat_valid;
    logic        feat_last,  sat_last;
    logic        overrun,    sat_overrun;
    logic [7:0]  drop_count, sat_drop_count;

    beat_t q_main[$];
    beat_t q_sat[$];
    beat_t e_main;
    beat_t e_sat;
    int    n_pass  = 0;
    int    n_total = 0;
    int    model_acc [NUM_BANDS];
    int    model_cnt = 0;
    bit    drop_next = 1'b0;

    always #5 clk = ~clk;

    mel_band_framer #(.FRAME_LEN(FL), .OUT_W(16), .OUT_SHIFT(8)) dut (
        .clk(clk), .rst(rst), .band_in(tb_in), .band_valid(tb_valid),
        .feat_data(feat_data), .feat_band(feat_band), .feat_valid(feat_valid),
        .feat_ready(tb_ready), .feat_last(feat_last), .overrun(overrun),
        .drop_count(drop_count)
    );

    mel_band_framer #(.FRAME_LEN(FL), .OUT_W(16), .OUT_SHIFT(0)) dut_sat (
        .clk(clk), .rst(rst), .band_in(tb_in), .band_valid(tb_valid),
        .feat_data(sat_data), .feat_band(sat_band), .feat_valid(sat_valid),
        .feat_ready(1'b1), .feat_last(sat_last), .overrun(sat_overrun),
        .drop_count(sat_drop_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_BANDS; i++) model_acc[i] = 0;
        model_cnt = 0;
    endtask

    // Reference accumulation of the stimulus just captured by the DUT.
    task automatic model_tick();
        beat_t b;
        int    v;
        int    sm;
        if (|tb_valid) begin
            for (int i = 0; i < NUM_BANDS; i++) begin
                if (tb_valid[i]) begin
                    v = int'(tb_in[i]);
                    model_acc[i] += (v < 0) ? -v : v;
                end
            end
            model_cnt++;
            if (model_cnt == FL) begin
                for (int i = 0; i < NUM_BANDS; i++) begin
                    sm     = model_acc[i] >> 8;
                    b.band = 4'(i);
                    b.last = (i == NUM_BANDS - 1);
                    b.data = (sm > 65535) ? 16'hFFFF : 16'(sm);
                    if (!drop_next) q_main.push_back(b);
                    b.data = (model_acc[i] > 65535) ? 16'hFFFF : 16'(model_acc[i]);
                    q_sat.push_back(b);
                    model_acc[i] = 0;
                end
                model_cnt = 0;
            end
        end
    endtask

    task automatic drive(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            model_tick();
        end
    endtask

    task automatic drive_random(input int n);
        for (int k = 0; k < n; k++) begin
            tb_valid = NUM_BANDS'($urandom_range(1, (1 << NUM_BANDS) - 1));
            for (int i = 0; i < NUM_BANDS; i++) tb_in[i] = band_sample_t'($urandom);
            @(posedge clk); #1;
            model_tick();
        end
    endtask

    task automatic set_all(input int v);
        for (int i = 0; i < NUM_BANDS; i++) tb_in[i] = band_sample_t'(v);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((q_main.size() != 0 || q_sat.size() != 0) && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("drain_main_empty", q_main.size(), 0);
        check("drain_sat_empty", q_sat.size(), 0);
        @(posedge clk); #1;
        check("idle_after_drain", feat_valid, 0);
    endtask

    // Scoreboard: compare each accepted beat against the model's queue.
    always @(negedge clk) begin
        if (!rst && feat_valid && tb_ready) begin
            check("main_beat_expected", q_main.size() != 0, 1);
            if (q_main.size() != 0) begin
                e_main = q_main.pop_front();
                check("main_data", feat_data, e_main.data);
                check("main_band", feat_band, e_main.band);
                check("main_last", feat_last, e_main.last);
            end
        end
        if (!rst && sat_valid) begin
            check("sat_beat_expected", q_sat.size() != 0, 1);
            if (q_sat.size() != 0) begin
                e_sat = q_sat.pop_front();
                check("sat_data", sat_data, e_sat.data);
                check("sat_band", sat_band, e_sat.band);
                check("sat_last", sat_last, e_sat.last);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(0);
        model_clear();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", feat_valid, 0);
        check("rst_band", feat_band, 0);
        check("rst_last", feat_last, 0);
        check("rst_overrun", overrun, 0);
        check("rst_drop", drop_count, 0);
        check("rst_sat_valid", sat_valid, 0);

        // Constant +100 on all bands, latency of feat_valid
        set_all(100);
        tb_valid = '1;
        drive(255);
        check("t1_valid_before_end", feat_valid, 0);
        drive(1);
        check("t1_valid_latency", feat_valid, 1);
        check("t1_band0", feat_band, 0);
        tb_valid = '0;
        drain();

        // Most negative sample on band 3
        set_all(0);
        tb_in[3] = -16'sd32768;
        tb_valid = '1;
        drive(FL);
        tb_valid = '0;
        drain();

        // Saturation (OUT_SHIFT=0 instance) with band 0 at +1000
        set_all(0);
        tb_in[0] = 16'sd1000;
        tb_valid = '1;
        drive(FL);
        tb_valid = '0;
        drain();

        // Backpressure across two frame ends
        tb_ready = 1'b0;
        for (int i = 0; i < NUM_BANDS; i++) tb_in[i] = band_sample_t'(50 * i - 300);
        tb_valid = '1;
        drive(FL);
        tb_valid = '0;
        for (int k = 0; k < 4; k++) begin
            check("bp_hold_valid", feat_valid, 1);
            check("bp_hold_band", feat_band, 0);
            check("bp_hold_data", feat_data, 300);
            check("bp_hold_last", feat_last, 0);
            @(posedge clk); #1;
        end
        drop_next = 1'b1;
        set_all(7);
        tb_valid = '1;
        drive(FL - 1);
        check("bp_no_overrun_early", overrun, 0);
        drive(1);
        tb_valid = '0;
        check("bp_overrun_pulse", overrun, 1);
        check("bp_drop_count", drop_count, 1);
        check("bp_still_band0", feat_band, 0);
        check("bp_still_data", feat_data, 300);
        @(posedge clk); #1;
        check("bp_overrun_one_cycle", overrun, 0);
        drop_next = 1'b0;
        tb_ready = 1'b1;
        drain();

        // Frame end coinciding with last-beat handshake
        tb_ready = 1'b0;
        drive_random(FL);
        drive_random(FL - 1);
        tb_valid = '0;
        for (int i = 0; i < NUM_BANDS; i++) tb_in[i] = band_sample_t'($urandom);
        tb_ready = 1'b1;
        drive(14);
        check("sim_at_last_band", feat_band, 14);
        check("sim_at_last_flag", feat_last, 1);
        drive_random(1);
        tb_valid = '0;
        check("sim_no_overrun", overrun, 0);
        check("sim_valid", feat_valid, 1);
        check("sim_band0", feat_band, 0);
        check("sim_new_data", feat_data, q_main[0].data);
        @(posedge clk); #1;
        check("sim_no_overrun_next", overrun, 0);
        check("sim_drop_unchanged", drop_count, 1);
        drain();

        // Reset mid-stream with ticks still running
        set_all(100);
        tb_valid = '1;
        drive(FL);
        for (int k = 0; k < 20 && feat_band != 4'd7; k++) drive(1);
        check("mid_at_beat7", feat_band, 7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q_main.delete();
        q_sat.delete();
        model_clear();
        check("mid_rst_valid", feat_valid, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_band", feat_band, 0);
        drive(FL - 1);
        check("mid_full_frame_pre", feat_valid, 0);
        drive(1);
        check("mid_full_frame_end", feat_valid, 1);
        tb_valid = '0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
